// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared NN constants and result drain state encoding
package nn_pkg;

  localparam int OUTPUT_FILE_SIZE = 16;
  localparam int IN_BUS_WIDTH     = 32;
  localparam int MEMORY_WIDTH     = 32;
  localparam int ADDRESS_SIZE     = 2**10;

  localparam int CNT_W     = $clog2(OUTPUT_FILE_SIZE) + 1;
  localparam int IDX_W     = $clog2(OUTPUT_FILE_SIZE);
  localparam int ADDR_BITS = $clog2(ADDRESS_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rr_state_t;

  // Requests larger than the output file are silently trimmed to its size.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    if (c > CNT_W'(OUTPUT_FILE_SIZE)) begin
      return CNT_W'(OUTPUT_FILE_SIZE);
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/result_reader.sv
// rtl/result_reader.sv - drains consecutive result words from data memory onto a valid/ready stream
module result_reader
  import nn_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    start,
  input  logic [IN_BUS_WIDTH-1:0] baseAdd,
  input  logic [CNT_W-1:0]        count,
  output logic [IN_BUS_WIDTH-1:0] memAdd,
  input  logic [MEMORY_WIDTH-1:0] memData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [MEMORY_WIDTH-1:0] outData,
  output logic [IDX_W-1:0]        outIndex,
  output logic                    outLast,
  output logic                    busy,
  output logic                    done
);

  rr_state_t                state, next_state;
  logic [IN_BUS_WIDTH-1:0]  base;
  logic [CNT_W-1:0]         rdPtr;
  logic [CNT_W-1:0]         cnt;
  logic                     capture;
  logic                     load;
  logic                     drop;

  // Address is derived from registered state only; the modulo wraps at the memory depth.
  assign memAdd = (base + IN_BUS_WIDTH'(rdPtr)) % IN_BUS_WIDTH'(ADDRESS_SIZE);
  assign busy   = (state == FETCH) || (state == SEND);
  assign done   = (state == DONE);

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes; a handshake with words left reloads the output register in place.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          next_state = (clamp_count(count) == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        load       = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        if (outReady) begin
          if (rdPtr == cnt) begin
            drop       = 1'b1;
            next_state = DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Drain bookkeeping and the single-stage output register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      base     <= '0;
      cnt      <= '0;
      rdPtr    <= '0;
      outData  <= '0;
      outIndex <= '0;
      outLast  <= 1'b0;
      outValid <= 1'b0;
    end else begin
      if (capture) begin
        base  <= baseAdd;
        cnt   <= clamp_count(count);
        rdPtr <= '0;
      end
      if (load) begin
        outData  <= memData;
        outIndex <= rdPtr[IDX_W-1:0];
        outLast  <= (rdPtr == cnt - CNT_W'(1));
        rdPtr    <= rdPtr + CNT_W'(1);
        outValid <= 1'b1;
      end else if (drop) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule
